// File: rtl/call_stack_pkg.sv
// Shared types and default geometry for the return-address stack.
package call_stack_pkg;

  localparam int ADDR_W = 19;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_SWAP
  } op_e;

  function automatic op_e decode_op(input logic en_stack,
                                    input logic call_en,
                                    input logic ret_en);
    if (!en_stack)              return OP_NONE;
    else if (call_en && ret_en) return OP_SWAP;
    else if (call_en)           return OP_PUSH;
    else if (ret_en)            return OP_POP;
    else                        return OP_NONE;
  endfunction

endpackage

// File: rtl/call_stack_mem.sv
// Return-address storage: DEPTH x ADDR_W register array with one synchronous
// write port and one asynchronous read port.
module stack_mem #(
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset on purpose; entries are only visible through
  // count, so stale data after reset is never observed.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack with zero-latency top-of-stack read.
// Build option: CALL_STACK_CIRCULAR_EN makes a push while full overwrite the oldest frame.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int ADDR_W = call_stack_pkg::ADDR_W,
  parameter int DEPTH  = call_stack_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_stack,
  input  logic                     call_en,
  input  logic                     ret_en,
  input  logic [ADDR_W-1:0]        ret_addr_in,
  input  logic                     clear,
  output logic [ADDR_W-1:0]        ret_addr_out,
  output logic                     ret_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wp_q, wp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              we;
  logic [PW-1:0]     waddr;
  logic [PW-1:0]     top_ptr;
  logic [ADDR_W-1:0] rdata;
  op_e               op;

  assign op      = decode_op(en_stack, call_en, ret_en);
  assign top_ptr = wp_q - PW'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = wp_q;
    if (clear) begin
      wp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          if (full) begin
            ovf_d = 1'b1;
`ifdef CALL_STACK_CIRCULAR_EN
            we    = 1'b1;
            wp_d  = wp_q + PW'(1);
`endif
          end else begin
            we    = 1'b1;
            wp_d  = wp_q + PW'(1);
            cnt_d = cnt_q + CW'(1);
          end
        end
        OP_POP: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            wp_d  = wp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end
        end
        OP_SWAP: begin
          // Tail-call replace; on an empty stack it degenerates to a push.
          we = 1'b1;
          if (empty) begin
            wp_d  = wp_q + PW'(1);
            cnt_d = cnt_q + CW'(1);
          end else begin
            waddr = top_ptr;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  stack_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (ret_addr_in),
    .raddr (top_ptr),
    .rdata (rdata)
  );

  assign ret_addr_out = empty ? '0 : rdata;
  assign ret_valid    = ~empty;
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed self-checking bench for call_stack (default geometry 19 x 8).
module tb_call_stack;

  localparam int AW = 19;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_stack;
  logic          call_en;
  logic          ret_en;
  logic [AW-1:0] ret_addr_in;
  logic          clear;
  logic [AW-1:0] ret_addr_out;
  logic          ret_valid;
  logic          full;
  logic          empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  int n_tests = 0;
  int n_fail  = 0;

  call_stack #(.ADDR_W(AW), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_stack     (en_stack),
    .call_en      (call_en),
    .ret_en       (ret_en),
    .ret_addr_in  (ret_addr_in),
    .clear        (clear),
    .ret_addr_out (ret_addr_out),
    .ret_valid    (ret_valid),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic c, input logic r, input logic e, input logic [AW-1:0] a);
    call_en = c; ret_en = r; en_stack = e; ret_addr_in = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0);
    clear = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a);
    drive(1'b1, 1'b0, 1'b1, a);
    tick();
  endtask

  // Pop, checking the combinational top in the same cycle as the return.
  task automatic pop_check(input string tag, input logic [AW-1:0] exp);
    drive(1'b0, 1'b1, 1'b1, '0);
    #1;
    check(tag, ret_addr_out, exp);
    tick();
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".empty"}, empty, 1);
    check({tag, ".count"}, count, 0);
    check({tag, ".valid"}, ret_valid, 0);
    check({tag, ".top"},   ret_addr_out, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    #22 rst = 1'b1;
    tick();
    tick();

    // Reset then idle
    check_empty("rst");
    check("rst.full", full, 0);
    check("rst.ovf", overflow, 0);
    check("rst.unf", underflow, 0);

    // LIFO order with same-cycle top on return
    push(19'h00010);
    push(19'h00020);
    push(19'h00030);
    check("lifo.count", count, 3);
    check("lifo.top", ret_addr_out, 19'h00030);
    pop_check("lifo.pop0", 19'h00030);
    pop_check("lifo.pop1", 19'h00020);
    pop_check("lifo.pop2", 19'h00010);
    check_empty("lifo.end");

    // Fill past capacity (also wraps the write pointer)
    for (int i = 1; i <= 9; i++) push(AW'(i));
    check("fill.full", full, 1);
    check("fill.count", count, D);
    check("fill.ovf", overflow, 1);
`ifdef CALL_STACK_CIRCULAR_EN
    check("fill.top", ret_addr_out, 9);
    for (int i = 0; i < 8; i++) pop_check($sformatf("fill.pop%0d", i), AW'(9 - i));
`else
    check("fill.top", ret_addr_out, 8);
    for (int i = 0; i < 8; i++) pop_check($sformatf("fill.pop%0d", i), AW'(8 - i));
`endif
    check_empty("fill.end");
    check("fill.ovf_sticky", overflow, 1);

    // Underflow, then clear wipes the sticky flags
    pop_check("unf.top", 19'h0);
    check("unf.flag", underflow, 1);
    check("unf.count", count, 0);
    clear = 1'b1;
    tick();
    check("clr.unf", underflow, 0);
    check("clr.ovf", overflow, 0);

    // clear wins over a simultaneous push
    clear = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 19'h00055);
    tick();
    check_empty("clr_prio");

    // Tail-call swap
    push(19'h00100);
    drive(1'b1, 1'b1, 1'b1, 19'h00200);
    tick();
    check("swap.count", count, 1);
    check("swap.top", ret_addr_out, 19'h00200);
    pop_check("swap.pop", 19'h00200);
    check_empty("swap.end");

    // Swap on empty acts as push
    drive(1'b1, 1'b1, 1'b1, 19'h00333);
    tick();
    check("swap_e.count", count, 1);
    check("swap_e.top", ret_addr_out, 19'h00333);
    pop_check("swap_e.pop", 19'h00333);

    // Strobes ignored without en_stack
    drive(1'b1, 1'b0, 1'b0, 19'h00444);
    tick();
    check_empty("noen.push");
    push(19'h00011);
    drive(1'b0, 1'b1, 1'b0, '0);
    tick();
    check("noen.pop.count", count, 1);
    check("noen.pop.top", ret_addr_out, 19'h00011);
    pop_check("noen.drain", 19'h00011);

    // Asynchronous reset mid-cycle with a push in flight
    push(19'h7FFFF);
    check("arst.pre.top", ret_addr_out, 19'h7FFFF);
    drive(1'b1, 1'b0, 1'b1, 19'h12345);
    #2 rst = 1'b0;
    #1;
    check("arst.now.empty", empty, 1);
    check("arst.now.count", count, 0);
    @(posedge clk);
    #1;
    check_empty("arst.hold");
    drive(1'b0, 1'b0, 1'b0, '0);
    #2 rst = 1'b1;
    tick();
    tick();
    check_empty("arst.after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
